// File: rtl/ram_stream_reader_if.sv
// Valid/ready word stream leaving ram_stream_reader; master is the reader, slave is the consumer.
// The oLast sideband exists only when STREAM_READER_LAST_EN is defined.
interface ram_stream_reader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  oValid;
    logic [DATA_WIDTH-1:0] oData;
    logic                  iReady;
`ifdef STREAM_READER_LAST_EN
    logic                  oLast;
`endif

    modport master (
        output oValid,
        output oData,
        input  iReady
`ifdef STREAM_READER_LAST_EN
        , output oLast
`endif
    );

    modport slave (
        input  oValid,
        input  oData,
        output iReady
`ifdef STREAM_READER_LAST_EN
        , input  oLast
`endif
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Reads iLength consecutive words from a 1-cycle-latency RAM and streams them through a 3-entry skid FIFO.
// Optional macro STREAM_READER_LAST_EN adds stream.oLast, flagging the final word of a transfer.
module ram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddress,
    input  logic [LEN_WIDTH-1:0]  iLength,
    output logic                  oBusy,
    output logic                  oDone,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [DATA_WIDTH-1:0] iReadData,
    ram_stream_reader_if.master   stream
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state, stateNext;
    logic [LEN_WIDTH-1:0]  length, issued, delivered;
    logic                  issuedPrev;
    logic [DATA_WIDTH-1:0] fifoMem [3];
    logic [1:0]            rdPtr, wrPtr, fifoCount;
    logic [2:0]            occupancy;
    logic                  issue, pop, lastPop;

    // A read may only issue if its data is guaranteed a FIFO slot, counting the read still in flight.
    always_comb begin
        occupancy = {1'b0, fifoCount} + {2'b00, issuedPrev};
        issue     = (state == RUN) && (issued != length) && (occupancy < 3'd3);
        pop       = (fifoCount != 2'd0) && stream.iReady;
        lastPop   = pop && ((delivered + LEN_WIDTH'(1)) == length);
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (iStart) stateNext = (iLength == '0) ? DONE : RUN;
            RUN:     if (issued == length) stateNext = DRAIN;
            DRAIN:   if (lastPop || (delivered == length)) stateNext = DONE;
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Transfer bookkeeping; an accepted start restarts every counter and the address.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            length       <= '0;
            issued       <= '0;
            delivered    <= '0;
            issuedPrev   <= 1'b0;
            oReadAddress <= '0;
        end else begin
            issuedPrev <= issue;
            if (state == IDLE && iStart) begin
                length       <= iLength;
                issued       <= '0;
                delivered    <= '0;
                oReadAddress <= iBaseAddress;
            end else begin
                if (issue) begin
                    issued       <= issued + LEN_WIDTH'(1);
                    oReadAddress <= oReadAddress + ADDR_WIDTH'(1);
                end
                if (pop) delivered <= delivered + LEN_WIDTH'(1);
            end
        end
    end

    // Skid FIFO: RAM data lands one cycle after its issue; reset drops anything still in flight.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < 3; i++) fifoMem[i] <= '0;
            rdPtr     <= 2'd0;
            wrPtr     <= 2'd0;
            fifoCount <= 2'd0;
        end else begin
            if (issuedPrev) begin
                fifoMem[wrPtr] <= iReadData;
                wrPtr          <= (wrPtr == 2'd2) ? 2'd0 : wrPtr + 2'd1;
            end
            if (pop) rdPtr <= (rdPtr == 2'd2) ? 2'd0 : rdPtr + 2'd1;
            case ({issuedPrev, pop})
                2'b10:   fifoCount <= fifoCount + 2'd1;
                2'b01:   fifoCount <= fifoCount - 2'd1;
                default: fifoCount <= fifoCount;
            endcase
        end
    end

    always_comb begin
        oBusy         = (state != IDLE);
        oDone         = (state == DONE);
        stream.oValid = (fifoCount != 2'd0);
        stream.oData  = fifoMem[rdPtr];
`ifdef STREAM_READER_LAST_EN
        stream.oLast  = (fifoCount != 2'd0) && ((delivered + LEN_WIDTH'(1)) == length);
`endif
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a registered RAM whose word is address^seed feeds the DUT,
// and each scenario task predicts the stream from base/length arithmetic.
module tb_ram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int LW = 16;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          iStart = 1'b0;
    logic [AW-1:0] iBaseAddress = '0;
    logic [LW-1:0] iLength = '0;
    logic          oBusy, oDone;
    logic [AW-1:0] oReadAddress;
    logic [DW-1:0] iReadData;
    logic [DW-1:0] ramSeed = '0;
    int            compared = 0;
    int            mismatched = 0;

    ram_stream_reader_if #(.DATA_WIDTH(DW)) streamIf ();

    ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iBaseAddress (iBaseAddress),
        .iLength      (iLength),
        .oBusy        (oBusy),
        .oDone        (oDone),
        .oReadAddress (oReadAddress),
        .iReadData    (iReadData),
        .stream       (streamIf.master)
    );

    always #5 Clock = ~Clock;

    // Registered-output RAM model: one cycle of read latency.
    always @(posedge Clock) iReadData <= DW'(oReadAddress) ^ ramSeed;

    function automatic logic [DW-1:0] expWord(input logic [AW-1:0] base, input int idx);
        logic [AW-1:0] a;
        a = base + AW'(idx);
        return DW'(a) ^ ramSeed;
    endfunction

    // Drives a start request across one edge; returns in cycle 1 of the transfer.
    task automatic applyStimulus(input logic [AW-1:0] base, input logic [LW-1:0] len);
        iStart       = 1'b1;
        iBaseAddress = base;
        iLength      = len;
        @(posedge Clock);
        @(negedge Clock);
        iStart = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        streamIf.iReady = 1'b0;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        compared++;
        if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", oBusy); end
        compared++;
        if (oDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0", oDone); end
        compared++;
        if (streamIf.oValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", streamIf.oValid); end
        compared++;
        if (streamIf.oData !== '0) begin mismatched++; $display("[TB] FAIL reset_data: got %h expected 0", streamIf.oData); end
        compared++;
        if (oReadAddress !== '0) begin mismatched++; $display("[TB] FAIL reset_addr: got %h expected 0", oReadAddress); end
        Reset = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Cycle-exact check of the documented latency with iReady held high.
    task automatic test_basic();
        logic expValid;
        ramSeed = '0;
        streamIf.iReady = 1'b1;
        applyStimulus(16'h0010, 16'd4);
        for (int c = 1; c <= 8; c++) begin
            expValid = (c >= 3) && (c <= 6);
            if (c == 1) begin
                compared++;
                if (oBusy !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy: got %b expected 1", oBusy); end
                compared++;
                if (oReadAddress !== 16'h0010) begin mismatched++; $display("[TB] FAIL basic_addr: got %h expected 0010", oReadAddress); end
            end
            compared++;
            if (streamIf.oValid !== expValid) begin mismatched++; $display("[TB] FAIL basic_valid c%0d: got %b expected %b", c, streamIf.oValid, expValid); end
            compared++;
            if (oDone !== (c == 7)) begin mismatched++; $display("[TB] FAIL basic_done c%0d: got %b expected %b", c, oDone, (c == 7)); end
            if (expValid) begin
                compared++;
                if (streamIf.oData !== DW'(16'h0010 + c - 3)) begin
                    mismatched++; $display("[TB] FAIL basic_data c%0d: got %h expected %h", c, streamIf.oData, DW'(16'h0010 + c - 3));
                end
            end
`ifdef STREAM_READER_LAST_EN
            compared++;
            if (streamIf.oLast !== (c == 6)) begin mismatched++; $display("[TB] FAIL basic_last c%0d: got %b expected %b", c, streamIf.oLast, (c == 6)); end
`endif
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic test_zero_length();
        streamIf.iReady = 1'b1;
        applyStimulus($urandom_range(0, 16'hFFFF), 16'd0);
        compared++;
        if (oDone !== 1'b1) begin mismatched++; $display("[TB] FAIL zero_done: got %b expected 1", oDone); end
        for (int c = 1; c <= 4; c++) begin
            compared++;
            if (streamIf.oValid !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_valid c%0d: got %b expected 0", c, streamIf.oValid); end
            @(posedge Clock);
            @(negedge Clock);
        end
        compared++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL zero_idle: got done=%b busy=%b expected 0/0", oDone, oBusy); end
    endtask

    // Randomized transfers under back-pressure, including the alternating-ready and address-wrap cases.
    task automatic test_random_stream();
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        logic [DW-1:0] prevData;
        logic          prevStall, doneSeen;
        int            got;
        for (int iter = 0; iter < 8; iter++) begin
            ramSeed = $urandom;
            base = (iter == 1) ? 16'hFFFE : AW'($urandom);
            len  = (iter == 0) ? 16'd8 : (iter == 1) ? 16'd4 : LW'($urandom_range(1, 20));
            streamIf.iReady = 1'b1;
            applyStimulus(base, len);
            compared++;
            if (oReadAddress !== base || oBusy !== 1'b1) begin
                mismatched++; $display("[TB] FAIL stream_start it%0d: got addr=%h busy=%b expected %h/1", iter, oReadAddress, oBusy, base);
            end
            got = 0;
            prevStall = 1'b0;
            prevData = '0;
            doneSeen = 1'b0;
            for (int c = 1; c < 400 && !doneSeen; c++) begin
                streamIf.iReady = (iter == 0) ? c[0] : 1'($urandom_range(0, 1));
                if (oDone) begin
                    doneSeen = 1'b1;
                    compared++;
                    if (got != int'(len)) begin mismatched++; $display("[TB] FAIL stream_count it%0d: got %0d words expected %0d", iter, got, len); end
                end else begin
                    if (prevStall) begin
                        compared++;
                        if (streamIf.oValid !== 1'b1 || streamIf.oData !== prevData) begin
                            mismatched++; $display("[TB] FAIL stream_hold it%0d: got %b/%h expected 1/%h", iter, streamIf.oValid, streamIf.oData, prevData);
                        end
                    end
                    if (streamIf.oValid && streamIf.iReady) begin
                        compared++;
                        if (got >= int'(len) || streamIf.oData !== expWord(base, got)) begin
                            mismatched++; $display("[TB] FAIL stream_data it%0d w%0d: got %h expected %h", iter, got, streamIf.oData, expWord(base, got));
                        end
                        got++;
                    end
                    prevStall = streamIf.oValid && !streamIf.iReady;
                    prevData  = streamIf.oData;
                end
                @(posedge Clock);
                @(negedge Clock);
            end
            compared++;
            if (!doneSeen) begin mismatched++; $display("[TB] FAIL stream_timeout it%0d: got no done expected done", iter); end
            compared++;
            if (oBusy !== 1'b0 || streamIf.oValid !== 1'b0) begin
                mismatched++; $display("[TB] FAIL stream_idle it%0d: got busy=%b valid=%b expected 0/0", iter, oBusy, streamIf.oValid);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] base;
        ramSeed = $urandom;
        base = AW'($urandom);
        streamIf.iReady = 1'b1;
        applyStimulus(base, 16'd6);
        repeat (4) begin @(posedge Clock); @(negedge Clock); end
        compared++;
        if (streamIf.oValid !== 1'b1 || streamIf.oData !== expWord(base, 2)) begin
            mismatched++; $display("[TB] FAIL midreset_word3: got %b/%h expected 1/%h", streamIf.oValid, streamIf.oData, expWord(base, 2));
        end
        Reset = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        Reset = 1'b0;
        compared++;
        if (streamIf.oValid !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            mismatched++; $display("[TB] FAIL midreset_clear: got valid=%b busy=%b done=%b expected 0/0/0", streamIf.oValid, oBusy, oDone);
        end
        repeat (3) begin @(posedge Clock); @(negedge Clock); end
        compared++;
        if (streamIf.oValid !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_stale: got %b expected 0", streamIf.oValid); end
        base = AW'($urandom);
        applyStimulus(base, 16'd3);
        for (int c = 1; c <= 7; c++) begin
            compared++;
            if (streamIf.oValid !== (c >= 3 && c <= 5) || oDone !== (c == 6)) begin
                mismatched++; $display("[TB] FAIL restart_flags c%0d: got valid=%b done=%b expected %b/%b", c, streamIf.oValid, oDone, (c >= 3 && c <= 5), (c == 6));
            end
            if (c >= 3 && c <= 5) begin
                compared++;
                if (streamIf.oData !== expWord(base, c - 3)) begin
                    mismatched++; $display("[TB] FAIL restart_data c%0d: got %h expected %h", c, streamIf.oData, expWord(base, c - 3));
                end
            end
            @(posedge Clock);
            @(negedge Clock);
        end
    endtask

    task automatic test_ignore_start();
        logic [AW-1:0] base;
        ramSeed = $urandom;
        base = AW'($urandom);
        streamIf.iReady = 1'b1;
        applyStimulus(base, 16'd5);
        for (int c = 1; c <= 9; c++) begin
            iStart = (c == 2 || c == 4);
            iBaseAddress = AW'($urandom);
            iLength = LW'($urandom_range(1, 30));
            compared++;
            if (streamIf.oValid !== (c >= 3 && c <= 7) || oDone !== (c == 8)) begin
                mismatched++; $display("[TB] FAIL ignore_flags c%0d: got valid=%b done=%b expected %b/%b", c, streamIf.oValid, oDone, (c >= 3 && c <= 7), (c == 8));
            end
            if (c >= 3 && c <= 7) begin
                compared++;
                if (streamIf.oData !== expWord(base, c - 3)) begin
                    mismatched++; $display("[TB] FAIL ignore_data c%0d: got %h expected %h", c, streamIf.oData, expWord(base, c - 3));
                end
            end
            @(posedge Clock);
            @(negedge Clock);
        end
        iStart = 1'b0;
        compared++;
        if (oBusy !== 1'b0) begin mismatched++; $display("[TB] FAIL ignore_idle: got busy=%b expected 0", oBusy); end
    endtask

    initial begin
        streamIf.iReady = 1'b0;
        @(negedge Clock);
        test_reset();
        test_basic();
        test_zero_length();
        test_random_stream();
        test_reset_mid();
        test_ignore_start();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
